// File: rtl/jedro_1_sig_dumper_pkg.sv
// Shared definitions for the RISCOF signature dumper: cell addresses, halt magic and FSM states.
package jedro_1_riscof_pkg;

  localparam logic [31:0] HALT_MAGIC = 32'h1;

  typedef enum logic [2:0] {
    RUN,
    HALT,
    RD_REQ,
    RD_WAIT,
    OUT,
    DONE
  } sig_state_e;

  // The three control cells sit in the top words of data memory.
  function automatic longint unsigned start_cell_addr(input longint unsigned mem_words);
    return (mem_words - 1) * 4;
  endfunction

  function automatic longint unsigned end_cell_addr(input longint unsigned mem_words);
    return (mem_words - 2) * 4;
  endfunction

  function automatic longint unsigned halt_cell_addr(input longint unsigned mem_words);
    return (mem_words - 3) * 4;
  endfunction

endpackage

// File: rtl/jedro_1_sig_dumper.sv
// Snoops core stores for signature bounds and halt, enforces a run timeout, then
// streams the signature region out of data memory over a valid/ready port.
module jedro_1_sig_dumper
  import jedro_1_riscof_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_SIZE_WORDS = 1 << 19,
  parameter int unsigned TIMEOUT        = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  snp_req_i,
  input  logic [3:0]            snp_we_i,
  input  logic [ADDR_WIDTH-1:0] snp_addr_i,
  input  logic [DATA_WIDTH-1:0] snp_wdata_i,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic                  rd_rvalid_i,
  input  logic [DATA_WIDTH-1:0] rd_rdata_i,
  input  logic                  rd_err_i,
  output logic                  sig_valid_o,
  output logic [DATA_WIDTH-1:0] sig_data_o,
  input  logic                  sig_ready_i,
  output logic                  halted_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] word_cnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(start_cell_addr(64'(MEM_SIZE_WORDS)));
  localparam logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(end_cell_addr(64'(MEM_SIZE_WORDS)));
  localparam logic [ADDR_WIDTH-1:0] HALT_ADDR  = ADDR_WIDTH'(halt_cell_addr(64'(MEM_SIZE_WORDS)));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  sig_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [ADDR_WIDTH-1:0] sig_start_q, sig_start_d;
  logic [ADDR_WIDTH-1:0] sig_end_q, sig_end_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] sig_data_q, sig_data_d;
  logic                  halted_q, halted_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;

  logic                  snp_full;
  logic [ADDR_WIDTH-1:0] wdata_aligned;
  logic [ADDR_WIDTH:0]   ptr_inc;

  assign snp_full      = snp_req_i && (snp_we_i == 4'b1111);
  assign wdata_aligned = ADDR_WIDTH'(snp_wdata_i) & ALIGN_MASK;
  // Extra carry bit lets a wrap past the top of the address space end the dump.
  assign ptr_inc       = {1'b0, rd_ptr_q} + {{(ADDR_WIDTH-2){1'b0}}, 3'd4};

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    sig_start_d = sig_start_q;
    sig_end_d   = sig_end_q;
    rd_ptr_d    = rd_ptr_q;
    word_cnt_d  = word_cnt_q;
    sig_data_d  = sig_data_q;
    halted_d    = halted_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    unique case (state_q)
      RUN: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (snp_full && snp_addr_i == START_ADDR) sig_start_d = wdata_aligned;
        if (snp_full && snp_addr_i == END_ADDR)   sig_end_d   = wdata_aligned;
        if (snp_full && snp_addr_i == HALT_ADDR && snp_wdata_i == DATA_WIDTH'(HALT_MAGIC)) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (cyc_cnt_q == CNT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      HALT: begin
        rd_ptr_d = sig_start_q;
        if (sig_start_q >= sig_end_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (rd_err_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_err_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (rd_rvalid_i) begin
          sig_data_d = rd_rdata_i;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (sig_ready_i) begin
          word_cnt_d = word_cnt_q + 1'b1;
          rd_ptr_d   = ptr_inc[ADDR_WIDTH-1:0];
          if (ptr_inc[ADDR_WIDTH] || ptr_inc[ADDR_WIDTH-1:0] >= sig_end_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RUN;
      cyc_cnt_q   <= '0;
      sig_start_q <= '0;
      sig_end_q   <= '0;
      rd_ptr_q    <= '0;
      word_cnt_q  <= '0;
      sig_data_q  <= '0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      sig_start_q <= sig_start_d;
      sig_end_q   <= sig_end_d;
      rd_ptr_q    <= rd_ptr_d;
      word_cnt_q  <= word_cnt_d;
      sig_data_q  <= sig_data_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign rd_req_o    = (state_q == RD_REQ);
  assign rd_addr_o   = rd_req_o ? rd_ptr_q : '0;
  assign sig_valid_o = (state_q == OUT);
  assign sig_data_o  = sig_data_q;
  assign halted_o    = halted_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
